// File: rtl/humidity_alarm_monitor_if.sv
// Bus bundle for humidity_alarm_monitor: raw sensor bits and acknowledge in,
// seven-segment digit, alarm and per-channel sticky LEDs out.
interface humidity_alarm_monitor_if #(
  parameter int NCH = 2
);
  logic [NCH-1:0] sens_low;
  logic           ack;
  logic [7:0]     seg;
  logic           alarm;
  logic [NCH-1:0] led;

  modport master (output sens_low, output ack, input seg, input alarm, input led);
  modport slave  (input sens_low, input ack, output seg, output alarm, output led);
endinterface

// File: rtl/humidity_alarm_monitor.sv
// Multi-channel low-humidity monitor: per-channel debounce, low-channel count
// shown on one 7-segment digit, delayed latched alarm with acknowledge and
// sticky per-channel LEDs.
// Optional feature macro: HUM_BLINK_EN (blinks dp every BLINK_HALF cycles while
// the alarm is latched; when undefined dp is steady and BLINK_HALF is unused).
module humidity_alarm_monitor #(
  parameter int NCH         = 2,
  parameter int FILT        = 4,
  parameter int ALARM_DELAY = 8,
  parameter int BLINK_HALF  = 4
) (
  input  logic                    clk_2,
  input  logic                    reset_n,
  humidity_alarm_monitor_if.slave bus
);

  localparam int CW = $clog2(FILT + 1);
  localparam int DW = $clog2(ALARM_DELAY + 1);
  localparam int NW = $clog2(NCH + 1);

  if (NCH < 1 || NCH > 9) begin : g_bad_nch
    $error("humidity_alarm_monitor: NCH must be 1..9");
  end
  if (FILT < 1) begin : g_bad_filt
    $error("humidity_alarm_monitor: FILT must be >= 1");
  end
  if (ALARM_DELAY < 1) begin : g_bad_delay
    $error("humidity_alarm_monitor: ALARM_DELAY must be >= 1");
  end
  if (BLINK_HALF < 1) begin : g_bad_blink
    $error("humidity_alarm_monitor: BLINK_HALF must be >= 1");
  end

  typedef enum logic [1:0] {S_OK, S_WAIT, S_ALARM, S_ACK} state_t;

  logic [NCH-1:0] filt_q, filt_d;
  logic [NCH-1:0] filt_prev_q;
  logic [NCH-1:0] led_q, led_d;
  logic [6:0]     seg_hi_q, seg_hi_d;
  logic [NCH-1:0] rise;
  logic [NW-1:0]  nlow;

  state_t         state_q;
  logic [DW-1:0]  dcnt_q;
  logic           alarm_q;
  logic           dp_q;

  // Per-channel debounce: a new raw value is accepted only after FILT
  // consecutive samples that differ from the accepted value.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_filt
    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_nxt;

    // Run-length count of samples disagreeing with the accepted value
    always_comb begin
      cnt_d    = '0;
      filt_nxt = filt_q[gi];
      if (bus.sens_low[gi] != filt_q[gi]) begin
        if (cnt_q == CW'(FILT - 1)) begin
          filt_nxt = bus.sens_low[gi];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    assign filt_d[gi] = filt_nxt;

    // Debounce counter register
    always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  // Newly asserted channels, seen one cycle after the debounced value changes
  assign rise = filt_q & ~filt_prev_q;

  // Number of debounced low channels
  always_comb begin
    nlow = '0;
    for (int i = 0; i < NCH; i++) begin
      nlow = nlow + NW'(filt_q[i]);
    end
  end

  // Segments a..g for the low-channel count (dp lives in the FSM)
  always_comb begin
    case (4'(nlow))
      4'd1:    seg_hi_d = 7'b0110000;
      4'd2:    seg_hi_d = 7'b1101101;
      4'd3:    seg_hi_d = 7'b1111001;
      4'd4:    seg_hi_d = 7'b0110011;
      4'd5:    seg_hi_d = 7'b1011011;
      4'd6:    seg_hi_d = 7'b1011111;
      4'd7:    seg_hi_d = 7'b1110000;
      4'd8:    seg_hi_d = 7'b1111111;
      4'd9:    seg_hi_d = 7'b1111011;
      default: seg_hi_d = 7'b0000000;
    endcase
  end

  // Sticky LEDs: a rise sets, an ack clears channels that are currently fine;
  // set wins if both happen together
  always_comb begin
    led_d = led_q;
    for (int i = 0; i < NCH; i++) begin
      if (rise[i]) begin
        led_d[i] = 1'b1;
      end else if (bus.ack && !filt_q[i]) begin
        led_d[i] = 1'b0;
      end
    end
  end

  // Debounced values, their one-cycle history, LEDs and digit segments
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      filt_q      <= '0;
      filt_prev_q <= '0;
      led_q       <= '0;
      seg_hi_q    <= '0;
    end else begin
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      led_q       <= led_d;
      seg_hi_q    <= seg_hi_d;
    end
  end

`ifdef HUM_BLINK_EN
  localparam int BW = $clog2(BLINK_HALF + 1);
  logic [BW-1:0] bcnt_q;
`endif

  // Alarm FSM; alarm and dp are registered alongside the state so they
  // change on the same edge as the state they decode
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_OK;
      dcnt_q  <= '0;
      alarm_q <= 1'b0;
      dp_q    <= 1'b0;
`ifdef HUM_BLINK_EN
      bcnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_OK: begin
          alarm_q <= 1'b0;
          dp_q    <= 1'b0;
          if (nlow != '0) begin
            state_q <= S_WAIT;
            dcnt_q  <= '0;
          end
        end
        S_WAIT: begin
          if (nlow == '0) begin
            state_q <= S_OK;
          end else if (dcnt_q == DW'(ALARM_DELAY - 1)) begin
            state_q <= S_ALARM;
            alarm_q <= 1'b1;
            dp_q    <= 1'b1;
`ifdef HUM_BLINK_EN
            bcnt_q  <= '0;
`endif
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        S_ALARM: begin
          if (bus.ack) begin
            state_q <= (nlow == '0) ? S_OK : S_ACK;
            alarm_q <= 1'b0;
            dp_q    <= 1'b0;
          end else begin
            alarm_q <= 1'b1;
`ifdef HUM_BLINK_EN
            if (bcnt_q == BW'(BLINK_HALF - 1)) begin
              bcnt_q <= '0;
              dp_q   <= ~dp_q;
            end else begin
              bcnt_q <= bcnt_q + 1'b1;
            end
`else
            dp_q <= 1'b1;
`endif
          end
        end
        S_ACK: begin
          // A fresh fault re-arms the alarm immediately, no delay
          if (rise != '0) begin
            state_q <= S_ALARM;
            alarm_q <= 1'b1;
            dp_q    <= 1'b1;
`ifdef HUM_BLINK_EN
            bcnt_q  <= '0;
`endif
          end else begin
            alarm_q <= 1'b0;
            dp_q    <= 1'b0;
            if (nlow == '0) begin
              state_q <= S_OK;
            end
          end
        end
        default: begin
          state_q <= S_OK;
          alarm_q <= 1'b0;
          dp_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.seg   = {seg_hi_q, dp_q};
  assign bus.alarm = alarm_q;
  assign bus.led   = led_q;

endmodule
